// File: rtl/vs1003_stream_pkg.sv
// Shared definitions for the VS1003B SDI/SCI streaming controller.
// Optional SCI write path is built when VS_SCI_WRITE_EN is defined.
package vs1003_stream_pkg;

    localparam logic [7:0] VS_SCI_WRITE_OP    = 8'h02;
    localparam int         VS_BURST_DEFAULT   = 32;
    localparam int         VS_CLK_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
`ifdef VS_SCI_WRITE_EN
        SCI_SHIFT,
        SCI_DESEL,
`endif
        DESEL
    } state_t;

    // Byte idx of a FIFO word, idx 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/vs1003_stream_ctrl_spi_byte_tx.sv
// SPI mode-0 byte transmitter, MSB first. A start loads the byte and drives
// bit 7 immediately with SCLK low; start may be given in the done cycle so
// consecutive bytes run back to back with no gap.
module spi_byte_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       mosi,
    output logic       done
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic          half;
    logic          active;
    logic [7:0]    shreg;
    logic          last_tick;

    assign last_tick = (div_cnt == DW'(CLK_DIV - 1));
    assign done      = active & half & last_tick & (bit_cnt == 3'd7);

    // Half-period divider, bit sequencing and the shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active  <= 1'b0;
            shreg   <= '0;
            mosi    <= 1'b0;
            sclk    <= 1'b0;
            half    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            active  <= 1'b1;
            shreg   <= data;
            mosi    <= data[7];
            sclk    <= 1'b0;
            half    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            if (!last_tick) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                if (!half) begin
                    half <= 1'b1;
                    sclk <= 1'b1;
                end else begin
                    half <= 1'b0;
                    sclk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        mosi    <= shreg[6];
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vs1003_stream_ctrl.sv
// Streams 32-bit FIFO words into the VS1003B SDI port in DREQ-gated bursts
// framed by XDCS, counting bursts cut short by an empty FIFO.
// Define VS_SCI_WRITE_EN to add a single-register SCI write path.
module vs1003_stream_ctrl
    import vs1003_stream_pkg::*;
#(
    parameter int CLK_DIV     = VS_CLK_DIV_DEFAULT,
    parameter int BURST_BYTES = VS_BURST_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_q,
    input  logic        mp3_dreq,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        mp3_xdcs,
    output logic        mp3_xcs,
`ifdef VS_SCI_WRITE_EN
    input  logic        sci_req,
    input  logic [7:0]  sci_addr,
    input  logic [15:0] sci_data,
    output logic        sci_ack,
`endif
    output logic        busy,
    output logic [15:0] underrun_cnt
);
    localparam int BW = $clog2(BURST_BYTES + 1);

    state_t        state;
    logic          dreq_meta, dreq_s;
    logic [31:0]   word;
    logic [1:0]    byte_idx;
    logic [BW-1:0] burst_cnt;
    logic          tx_start, tx_done;
    logic [7:0]    tx_data;

    assign busy = (state != IDLE);

    // Two-flop synchroniser for the codec's asynchronous DREQ.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            dreq_meta <= 1'b0;
            dreq_s    <= 1'b0;
        end else begin
            dreq_meta <= mp3_dreq;
            dreq_s    <= dreq_meta;
        end
    end

    // Byte launch: first byte of a word comes straight from fifo_q in LOAD,
    // later bytes are chained off the previous byte's done pulse.
    always_comb begin
        tx_start = 1'b0;
        tx_data  = word_byte(word, byte_idx + 2'd1);
        case (state)
            LOAD: begin
                tx_start = 1'b1;
                tx_data  = fifo_q[31:24];
            end
            SHIFT: tx_start = tx_done && (byte_idx != 2'd3);
`ifdef VS_SCI_WRITE_EN
            IDLE: begin
                tx_start = sci_req && dreq_s;
                tx_data  = VS_SCI_WRITE_OP;
            end
            SCI_SHIFT: begin
                tx_start = tx_done && (byte_idx != 2'd3);
                tx_data  = word_byte({VS_SCI_WRITE_OP, sci_addr, sci_data}, byte_idx + 2'd1);
            end
`endif
            default: ;
        endcase
    end

    // Main sequencer; owns the chip selects, the pop strobe and the counters.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            fifo_rd_en   <= 1'b0;
            mp3_xdcs     <= 1'b1;
            underrun_cnt <= '0;
            word         <= '0;
            byte_idx     <= '0;
            burst_cnt    <= '0;
`ifdef VS_SCI_WRITE_EN
            mp3_xcs      <= 1'b1;
            sci_ack      <= 1'b0;
`endif
        end else begin
            fifo_rd_en <= 1'b0;
`ifdef VS_SCI_WRITE_EN
            sci_ack    <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef VS_SCI_WRITE_EN
                    if (sci_req && dreq_s) begin
                        state    <= SCI_SHIFT;
                        mp3_xcs  <= 1'b0;
                        byte_idx <= '0;
                    end else
`endif
                    if (enable && dreq_s && !fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                        burst_cnt  <= '0;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    word     <= fifo_q;
                    byte_idx <= '0;
                    mp3_xdcs <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (tx_done) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (burst_cnt == BW'(BURST_BYTES - 1) || !enable) begin
                                state    <= DESEL;
                                mp3_xdcs <= 1'b1;
                            end else if (fifo_empty) begin
                                if (underrun_cnt != 16'hFFFF)
                                    underrun_cnt <= underrun_cnt + 16'd1;
                                state    <= DESEL;
                                mp3_xdcs <= 1'b1;
                            end else begin
                                state      <= FETCH;
                                fifo_rd_en <= 1'b1;
                            end
                        end
                    end
                end
`ifdef VS_SCI_WRITE_EN
                SCI_SHIFT: begin
                    if (tx_done) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state   <= SCI_DESEL;
                            mp3_xcs <= 1'b1;
                            sci_ack <= 1'b1;
                        end
                    end
                end
                SCI_DESEL: state <= IDLE;
`endif
                DESEL:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef VS_SCI_WRITE_EN
    assign mp3_xcs = 1'b1;
`endif

    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk     (sys_clk),
        .reset_n (reset_n),
        .start   (tx_start),
        .data    (tx_data),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_vs1003_stream_ctrl.sv
// Directed bench for vs1003_stream_ctrl: FIFO model, SPI byte capture,
// table-driven burst vectors and hand-written corner sequences.
module tb_vs1003_stream_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_q = '0;
    logic        mp3_dreq = 1'b0;
    logic        spi_sclk, spi_mosi, mp3_xdcs, mp3_xcs, busy;
    logic [15:0] underrun_cnt;
`ifdef VS_SCI_WRITE_EN
    logic        sci_req = 1'b0;
    logic [7:0]  sci_addr = '0;
    logic [15:0] sci_data = '0;
    logic        sci_ack;
`endif

    always #5 sys_clk = ~sys_clk;

    vs1003_stream_ctrl #(.CLK_DIV(2), .BURST_BYTES(32)) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_q       (fifo_q),
        .mp3_dreq     (mp3_dreq),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .mp3_xdcs     (mp3_xdcs),
        .mp3_xcs      (mp3_xcs),
`ifdef VS_SCI_WRITE_EN
        .sci_req      (sci_req),
        .sci_addr     (sci_addr),
        .sci_data     (sci_data),
        .sci_ack      (sci_ack),
`endif
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    // FIFO model: words written by the stimulus, popped by the DUT.
    logic [31:0] fifo_mem [0:255];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    int          pops = 0;
    int          proto_err = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge sys_clk) begin
        if (fifo_rd_en && fifo_empty) proto_err++;
        if (!reset_n) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_q <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
            pops++;
        end
    end

    // SPI capture: bytes shifted on SCLK rise, split by which select is low.
    logic [7:0] sdi_buf [0:1023];
    logic [7:0] sci_buf [0:63];
    logic [7:0] sdi_sh = '0, sci_sh = '0;
    int sdi_bits = 0, sci_bits = 0, sdi_n = 0, sci_n = 0, frames = 0, overlap = 0;
    logic sclk_d = 1'b0, xdcs_d = 1'b1;

    always @(posedge sys_clk) begin
        if (!reset_n) begin
            sdi_bits = 0;
            sci_bits = 0;
        end else if (spi_sclk && !sclk_d) begin
            if (!mp3_xdcs) begin
                sdi_sh = {sdi_sh[6:0], spi_mosi};
                sdi_bits++;
                if (sdi_bits == 8) begin
                    sdi_buf[sdi_n % 1024] = sdi_sh;
                    sdi_n++;
                    sdi_bits = 0;
                end
            end
            if (!mp3_xcs) begin
                sci_sh = {sci_sh[6:0], spi_mosi};
                sci_bits++;
                if (sci_bits == 8) begin
                    sci_buf[sci_n % 64] = sci_sh;
                    sci_n++;
                    sci_bits = 0;
                end
            end
        end
        if (mp3_xdcs && !xdcs_d) frames++;
        if (!mp3_xcs && !mp3_xdcs) overlap++;
        sclk_d = spi_sclk;
        xdcs_d = mp3_xdcs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic push_words(input int n, input logic [7:0] base);
        logic [7:0] b;
        for (int w = 0; w < n; w++) begin
            b = base + 8'(4 * w);
            fifo_mem[wr_ptr] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_idle(input string nm);
        int quiet = 0;
        bit ok = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge sys_clk);
            #1;
            quiet = busy ? 0 : quiet + 1;
            if (quiet >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_bytes(input int target, input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge sys_clk);
            #1;
            if (sdi_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, "_byte_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_bytes(input string nm, input int s0, input int n, input logic [7:0] base);
        chk({nm, "_nbytes"}, 32'(sdi_n - s0), 32'(n));
        for (int k = 0; k < n && k < sdi_n - s0; k++)
            chk({nm, "_byte"}, 32'(sdi_buf[(s0 + k) % 1024]), 32'(base + 8'(k)));
    endtask

    typedef struct {
        string      name;
        int         n_words;
        logic [7:0] base;
        int         exp_bytes;
        int         exp_pops;
        int         exp_frames;
        logic [15:0] exp_under;
    } vec_t;

    vec_t vecs [4];
    int s0, p0, f0, k;

    initial begin
        vecs[0] = '{"full_burst",   8, 8'h00, 32,  8, 1, 16'd0};
        vecs[1] = '{"three_words",  3, 8'h40, 12,  3, 1, 16'd1};
        vecs[2] = '{"two_bursts",  10, 8'h80, 40, 10, 2, 16'd1};
        vecs[3] = '{"one_word",     1, 8'hC0,  4,  1, 1, 16'd1};

        // Reset state.
        do_reset();
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_sclk",  32'(spi_sclk), 32'd0);
        chk("rst_mosi",  32'(spi_mosi), 32'd0);
        chk("rst_xdcs",  32'(mp3_xdcs), 32'd1);
        chk("rst_xcs",   32'(mp3_xcs), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_under", 32'(underrun_cnt), 32'd0);

        // Table-driven bursts.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            enable = 1'b1;
            push_words(vecs[i].n_words, vecs[i].base);
            s0 = sdi_n; p0 = pops; f0 = frames;
            mp3_dreq = 1'b1;
            wait_idle(vecs[i].name);
            mp3_dreq = 1'b0;
            chk_bytes(vecs[i].name, s0, vecs[i].exp_bytes, vecs[i].base);
            chk({vecs[i].name, "_pops"},   32'(pops - p0), 32'(vecs[i].exp_pops));
            chk({vecs[i].name, "_frames"}, 32'(frames - f0), 32'(vecs[i].exp_frames));
            chk({vecs[i].name, "_under"},  32'(underrun_cnt), 32'(vecs[i].exp_under));
            chk({vecs[i].name, "_xdcs"},   32'(mp3_xdcs), 32'd1);
        end

        // DREQ low holds off the burst; latency from DREQ rise to first SCLK rise.
        do_reset();
        enable = 1'b1;
        push_words(8, 8'h00);
        p0 = pops; s0 = sdi_n;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge sys_clk);
            #1;
            if (busy || !mp3_xdcs) k++;
        end
        chk("nodreq_active", 32'(k), 32'd0);
        chk("nodreq_pops", 32'(pops - p0), 32'd0);
        mp3_dreq = 1'b1;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge sys_clk);
            #1;
            if (spi_sclk) begin
                k = c;
                break;
            end
        end
        chk("dreq_to_sclk", 32'(k), 32'd7);
        wait_idle("dreq_lat");
        mp3_dreq = 1'b0;
        chk_bytes("dreq_lat", s0, 32, 8'h00);

        // Underrun counter saturates.
        do_reset();
        enable = 1'b1;
        force dut.underrun_cnt = 16'hFFFF;
        @(posedge sys_clk);
        #1 release dut.underrun_cnt;
        chk("sat_preload", 32'(underrun_cnt), 32'h0000FFFF);
        push_words(1, 8'h20);
        s0 = sdi_n;
        mp3_dreq = 1'b1;
        wait_idle("sat");
        mp3_dreq = 1'b0;
        chk("sat_nbytes", 32'(sdi_n - s0), 32'd4);
        chk("sat_under", 32'(underrun_cnt), 32'h0000FFFF);

        // Enable dropped during byte 2 finishes the word, then stops.
        do_reset();
        enable = 1'b1;
        push_words(8, 8'h00);
        s0 = sdi_n; p0 = pops; f0 = frames;
        mp3_dreq = 1'b1;
        wait_bytes(s0 + 1, "en_drop");
        repeat (3) @(posedge sys_clk);
        #1 enable = 1'b0;
        wait_idle("en_drop");
        chk_bytes("en_drop", s0, 4, 8'h00);
        chk("en_drop_pops", 32'(pops - p0), 32'd1);
        chk("en_drop_frames", 32'(frames - f0), 32'd1);
        chk("en_drop_under", 32'(underrun_cnt), 32'd0);

        // Reset mid-byte aborts immediately.
        s0 = sdi_n;
        enable = 1'b1;
        wait_bytes(s0 + 1, "mid_rst");
        repeat (5) @(posedge sys_clk);
        #1 reset_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("mid_rst_sclk", 32'(spi_sclk), 32'd0);
        chk("mid_rst_xdcs", 32'(mp3_xdcs), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        reset_n = 1'b1;
        mp3_dreq = 1'b0;

        // DREQ dropped after the first byte does not shorten the burst.
        do_reset();
        enable = 1'b1;
        push_words(8, 8'h60);
        s0 = sdi_n; f0 = frames;
        mp3_dreq = 1'b1;
        wait_bytes(s0 + 1, "dreq_drop");
        mp3_dreq = 1'b0;
        wait_idle("dreq_drop");
        chk_bytes("dreq_drop", s0, 32, 8'h60);
        chk("dreq_drop_frames", 32'(frames - f0), 32'd1);

`ifdef VS_SCI_WRITE_EN
        // SCI write has priority over pending SDI data.
        do_reset();
        enable = 1'b1;
        push_words(2, 8'hA0);
        s0 = sdi_n; f0 = frames; p0 = sci_n; k = overlap;
        sci_addr = 8'h0B;
        sci_data = 16'h2020;
        sci_req = 1'b1;
        mp3_dreq = 1'b1;
        begin
            bit ok = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(posedge sys_clk);
                #1;
                if (sci_ack) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("sci_ack_seen", 32'(ok), 32'd1);
        end
        sci_req = 1'b0;
        chk("sci_nbytes", 32'(sci_n - p0), 32'd4);
        chk("sci_b0", 32'(sci_buf[(p0 + 0) % 64]), 32'h02);
        chk("sci_b1", 32'(sci_buf[(p0 + 1) % 64]), 32'h0B);
        chk("sci_b2", 32'(sci_buf[(p0 + 2) % 64]), 32'h20);
        chk("sci_b3", 32'(sci_buf[(p0 + 3) % 64]), 32'h20);
        chk("sci_no_sdi", 32'(sdi_n - s0), 32'd0);
        chk("sci_xcs_hi", 32'(mp3_xcs), 32'd1);
        @(posedge sys_clk);
        #1 chk("sci_ack_pulse", 32'(sci_ack), 32'd0);
        wait_idle("sci");
        mp3_dreq = 1'b0;
        chk_bytes("sci_then_sdi", s0, 8, 8'hA0);
        chk("sci_overlap", 32'(overlap - k), 32'd0);
`endif

        chk("protocol_pop_empty", 32'(proto_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
